// File: rtl/mips_pkg.sv
// Constants and state encoding shared by the fetch/PC sequencer and the npc block.
package mips_pkg;

    localparam logic [1:0] npc_nml = 2'b00;
    localparam logic [1:0] npc_beq = 2'b01;
    localparam logic [1:0] npc_j   = 2'b10;

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/pc_seq_if.sv
// Instruction-memory handshake plus the next-PC link between pc_seq and npc.
interface pc_seq_if;
    logic        imem_req;
    logic        imem_ack;
    logic [5:0]  opcode;
    logic [29:0] pc;
    logic [29:0] npc_pc;
    logic [1:0]  nPCOp;
    logic        zero_q;
    logic        start;

    modport master (
        output imem_req, pc, nPCOp, zero_q, start,
        input  imem_ack, opcode, npc_pc
    );

    modport slave (
        input  imem_req, pc, nPCOp, zero_q, start,
        output imem_ack, opcode, npc_pc
    );
endinterface

// File: rtl/pc_seq_op_decode.sv
// Combinational opcode decode: next-PC select and halt detection from the latched opcode.
module op_decode
    import mips_pkg::*;
(
    input  logic [5:0] op_q,
    output logic [1:0] sel,
    output logic       is_halt
);

    always_comb begin
        sel     = npc_nml;
        is_halt = 1'b0;
        case (op_q)
            OP_BEQ:  sel     = npc_beq;
            OP_J:    sel     = npc_j;
            OP_HALT: is_halt = 1'b1;
            default: sel     = npc_nml;
        endcase
    end

endmodule

// File: rtl/pc_seq.sv
// Multi-cycle fetch/PC sequencer: owns the PC, runs the imem handshake and steers npc.
module pc_seq
    import mips_pkg::*;
#(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst,
    pc_seq_if.master    bus,
    input  logic        stall,
    input  logic        alu_zero,
    output logic        halt,
    output logic [31:0] retired
);

    seq_state_t  state_reg;
    logic [29:0] pc_reg;
    logic [5:0]  op_q_reg;
    logic        imem_req_reg;
    logic [1:0]  npc_op_reg;
    logic        zero_q_reg;
    logic        start_reg;
    logic        halt_reg;
    logic [31:0] retired_reg;

    logic [1:0]  dec_sel;
    logic        dec_is_halt;

    op_decode u_op_decode (
        .op_q    (op_q_reg),
        .sel     (dec_sel),
        .is_halt (dec_is_halt)
    );

    // Outputs are registered alongside the state so each one changes on the
    // same edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            op_q_reg     <= 6'd0;
            imem_req_reg <= 1'b0;
            npc_op_reg   <= npc_nml;
            zero_q_reg   <= 1'b0;
            start_reg    <= 1'b1;
            halt_reg     <= 1'b0;
            retired_reg  <= 32'd0;
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    state_reg    <= ST_FETCH;
                    imem_req_reg <= 1'b1;
                end
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        op_q_reg     <= bus.opcode;
                        imem_req_reg <= 1'b0;
                        state_reg    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_is_halt) begin
                        halt_reg  <= 1'b1;
                        state_reg <= ST_HALT;
                    end else if (!stall) begin
                        zero_q_reg <= alu_zero;
                        npc_op_reg <= dec_sel;
                        start_reg  <= 1'b0;
                        state_reg  <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    pc_reg       <= bus.npc_pc;
                    retired_reg  <= retired_reg + 32'd1;
                    npc_op_reg   <= npc_nml;
                    start_reg    <= 1'b1;
                    imem_req_reg <= 1'b1;
                    state_reg    <= ST_FETCH;
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.imem_req = imem_req_reg;
    assign bus.pc       = pc_reg;
    assign bus.nPCOp    = npc_op_reg;
    assign bus.zero_q   = zero_q_reg;
    assign bus.start    = start_reg;
    assign halt         = halt_reg;
    assign retired      = retired_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq with a behavioural npc model closing the next-PC loop.
module tb_pc_seq;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        alu_zero;
    logic        halt;
    logic [31:0] retired;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [29:0] npc_next;

    int checks;
    int errors;

    pc_seq_if bus();

    pc_seq dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .stall    (stall),
        .alu_zero (alu_zero),
        .halt     (halt),
        .retired  (retired)
    );

    // npc model: beq target is pc + sext(imm16); j keeps pc[31:28] of the byte address.
    always_comb begin
        npc_next = bus.pc + 30'd1;
        if (!bus.start) begin
            case (bus.nPCOp)
                2'b01: if (bus.zero_q) npc_next = bus.pc + {{14{imm16[15]}}, imm16};
                2'b10: npc_next = {bus.pc[29:26], imm26};
                default: npc_next = bus.pc + 30'd1;
            endcase
        end
    end
    assign bus.npc_pc = npc_next;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from a FETCH state; a stray ack with the halt opcode is
    // injected during the stall window to confirm it is ignored outside FETCH.
    task automatic do_instr(input logic [5:0] op, input int ack_dly, input int stall_n,
                            input logic z, input logic [29:0] pc0, input logic [29:0] pc1,
                            input logic [1:0] sel, input int ret, input int exp_cyc);
        int cyc;
        cyc = 0;
        chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        for (int i = 0; i < ack_dly; i++) begin
            step();
            cyc++;
            chk("pc_wait", {2'b00, bus.pc}, {2'b00, pc0});
            chk("req_wait", {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ack = 1'b1;
        bus.opcode   = op;
        step();
        cyc++;
        bus.imem_ack = 1'b0;
        bus.opcode   = 6'd0;
        chk("exec_req", {31'd0, bus.imem_req}, 32'd0);
        chk("exec_start", {31'd0, bus.start}, 32'd1);
        chk("exec_sel", {30'd0, bus.nPCOp}, 32'd0);
        chk("pc_exec", {2'b00, bus.pc}, {2'b00, pc0});
        for (int i = 0; i < stall_n; i++) begin
            stall = 1'b1;
            if (i == 1) begin
                bus.imem_ack = 1'b1;
                bus.opcode   = 6'b111111;
            end
            step();
            cyc++;
            bus.imem_ack = 1'b0;
            bus.opcode   = 6'd0;
            chk("pc_stall", {2'b00, bus.pc}, {2'b00, pc0});
            chk("halt_stall", {31'd0, halt}, 32'd0);
        end
        stall    = 1'b0;
        alu_zero = z;
        step();
        cyc++;
        alu_zero = ~z;
        chk("upd_start", {31'd0, bus.start}, 32'd0);
        chk("upd_sel", {30'd0, bus.nPCOp}, {30'd0, sel});
        chk("upd_zero", {31'd0, bus.zero_q}, {31'd0, z});
        chk("pc_upd", {2'b00, bus.pc}, {2'b00, pc0});
        step();
        cyc++;
        alu_zero = 1'b0;
        chk("pc_after", {2'b00, bus.pc}, {2'b00, pc1});
        chk("retired", retired, ret);
        chk("post_start", {31'd0, bus.start}, 32'd1);
        chk("post_sel", {30'd0, bus.nPCOp}, 32'd0);
        chk("cycles", cyc, exp_cyc);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        stall        = 1'b0;
        alu_zero     = 1'b0;
        bus.imem_ack = 1'b0;
        bus.opcode   = 6'd0;
        imm16        = 16'hFFFE;
        imm26        = 26'h0000123;

        step(); step(); step();
        chk("rst_pc", {2'b00, bus.pc}, 32'h0000_0C00);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_start", {31'd0, bus.start}, 32'd1);
        chk("rst_sel", {30'd0, bus.nPCOp}, 32'd0);
        chk("rst_zero", {31'd0, bus.zero_q}, 32'd0);

        rst = 1'b1;
        chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);

        do_instr(6'd0, 0, 0, 1'b0, 30'h0C00, 30'h0C01, 2'b00, 1, 3);
        do_instr(6'd0, 0, 0, 1'b0, 30'h0C01, 30'h0C02, 2'b00, 2, 3);
        do_instr(6'd0, 0, 0, 1'b0, 30'h0C02, 30'h0C03, 2'b00, 3, 3);
        do_instr(6'd0, 0, 0, 1'b0, 30'h0C03, 30'h0C04, 2'b00, 4, 3);
        do_instr(6'd0, 0, 0, 1'b0, 30'h0C04, 30'h0C05, 2'b00, 5, 3);

        do_instr(6'b000100, 0, 0, 1'b1, 30'h0C05, 30'h0C03, 2'b01, 6, 3);
        do_instr(6'd0, 0, 0, 1'b0, 30'h0C03, 30'h0C04, 2'b00, 7, 3);
        do_instr(6'd0, 0, 0, 1'b0, 30'h0C04, 30'h0C05, 2'b00, 8, 3);
        do_instr(6'b000100, 0, 0, 1'b0, 30'h0C05, 30'h0C06, 2'b01, 9, 3);

        do_instr(6'b000010, 0, 0, 1'b0, 30'h0C06, 30'h0000123, 2'b10, 10, 3);

        do_instr(6'd0, 2, 3, 1'b0, 30'h0000123, 30'h0000124, 2'b00, 11, 8);

        bus.imem_ack = 1'b1;
        bus.opcode   = 6'b111111;
        step();
        bus.imem_ack = 1'b0;
        bus.opcode   = 6'd0;
        step();
        chk("halt_set", {31'd0, halt}, 32'd1);
        chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            bus.imem_ack = i[0];
            step();
            chk("halt_pc", {2'b00, bus.pc}, 32'h0000_0124);
            chk("halt_retired", retired, 32'd11);
            chk("halt_hold", {31'd0, halt}, 32'd1);
            chk("halt_noreq", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.imem_ack = 1'b0;

        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("reboot_pc", {2'b00, bus.pc}, 32'h0000_0C00);
        chk("reboot_halt", {31'd0, halt}, 32'd0);
        chk("reboot_retired", retired, 32'd0);
        step();
        chk("reboot_req", {31'd0, bus.imem_req}, 32'd1);
        do_instr(6'd0, 0, 0, 1'b0, 30'h0C00, 30'h0C01, 2'b00, 1, 3);

        rst = 1'b0;
        step();
        chk("midfetch_req", {31'd0, bus.imem_req}, 32'd0);
        chk("midfetch_pc", {2'b00, bus.pc}, 32'h0000_0C00);
        chk("midfetch_retired", retired, 32'd0);
        rst = 1'b1;
        step();
        chk("midfetch_reboot_req", {31'd0, bus.imem_req}, 32'd1);
        do_instr(6'd0, 1, 0, 1'b0, 30'h0C00, 30'h0C01, 2'b00, 1, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
